// File: rtl/decode_stage_pkg.sv
// Shared MIPS opcode/funct constants and ID-stage helpers.
// Imported by the decode stage and its register file.
package decode_stage_pkg;
   localparam logic [5:0] R_FORM = 6'h00;
   localparam logic [5:0] J      = 6'h02;
   localparam logic [5:0] JAL    = 6'h03;
   localparam logic [5:0] BEQ    = 6'h04;
   localparam logic [5:0] ADDI   = 6'h08;
   localparam logic [5:0] SLTI   = 6'h0a;
   localparam logic [5:0] LW     = 6'h23;
   localparam logic [5:0] SW     = 6'h2b;
   localparam logic [5:0] ADD    = 6'h20;
   localparam logic [5:0] JR     = 6'h08;
   localparam logic [4:0] REG_RA = 5'd31;

   // Architectural destination of an instruction; 0 means no register write.
   function automatic logic [4:0] dest_of(input logic [31:0] ins);
      case (ins[31:26])
         R_FORM:         dest_of = ins[15:11];
         LW, ADDI, SLTI: dest_of = ins[20:16];
         JAL:            dest_of = REG_RA;
         default:        dest_of = 5'd0;
      endcase
   endfunction
endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 general register file: two combinational read ports, one write port,
// r0 hard-wired to zero, write-to-read bypass and synchronous clear.
module regfile
   import decode_stage_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [4:0]  Raddr1,
   input  logic [4:0]  Raddr2,
   output logic [31:0] Rdata1,
   output logic [31:0] Rdata2,
   input  logic        WE,
   input  logic [4:0]  Waddr,
   input  logic [31:0] Wdata
);
   logic [31:0] r_mem [32];
   logic        w_wr;

   assign w_wr = WE && (Waddr != 5'd0);

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < 32; i++) r_mem[i] <= '0;
      end else if (w_wr) begin
         r_mem[Waddr] <= Wdata;
      end
   end

   // Write-back data in flight this cycle overrides the stored value.
   always_comb begin
      Rdata1 = '0;
      Rdata2 = '0;
      if (Raddr1 != 5'd0) Rdata1 = (w_wr && Waddr == Raddr1) ? Wdata : r_mem[Raddr1];
      if (Raddr2 != 5'd0) Rdata2 = (w_wr && Waddr == Raddr2) ? Wdata : r_mem[Raddr2];
   end
endmodule

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: register read, immediate sign extension,
// destination select, load-use hazard detect and the ID/EX pipeline register.
module decode_stage
   import decode_stage_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] InsIn,
   input  logic [31:0] nextPCIn,
   input  logic        Flush,
   input  logic        WE,
   input  logic [4:0]  Waddr,
   input  logic [31:0] Wdata,
   output logic [31:0] Ins,
   output logic [31:0] Rdata1,
   output logic [31:0] Rdata2,
   output logic [31:0] Ed32,
   output logic [31:0] nextPC,
   output logic [4:0]  Wreg,
   output logic        Stall
);
   logic [31:0] r_ins, r_rd1, r_rd2, r_ed32, r_npc;
   logic [4:0]  r_wreg;
   logic [31:0] w_rd1, w_rd2, w_ed32;
   logic [4:0]  w_rs, w_rt, w_dest;
   logic        w_stall;

   assign w_rs   = InsIn[25:21];
   assign w_rt   = InsIn[20:16];
   assign w_ed32 = {{16{InsIn[15]}}, InsIn[15:0]};
   assign w_dest = dest_of(InsIn);

   regfile u_rf (
      .CLK    (CLK),
      .RST    (RST),
      .Raddr1 (w_rs),
      .Raddr2 (w_rt),
      .Rdata1 (w_rd1),
      .Rdata2 (w_rd2),
      .WE     (WE),
      .Waddr  (Waddr),
      .Wdata  (Wdata)
   );

   // Compares both source fields regardless of opcode; a false stall only costs a cycle.
   assign w_stall = (r_ins[31:26] == LW) && (r_wreg != 5'd0) &&
                    ((r_wreg == w_rs) || (r_wreg == w_rt));

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ins  <= '0;
         r_rd1  <= '0;
         r_rd2  <= '0;
         r_ed32 <= '0;
         r_npc  <= '0;
         r_wreg <= '0;
      end else if (Flush || w_stall) begin
         // Bubble keeps nextPC coherent so EX sees no redirect.
         r_ins  <= '0;
         r_rd1  <= '0;
         r_rd2  <= '0;
         r_ed32 <= '0;
         r_npc  <= nextPCIn;
         r_wreg <= '0;
      end else begin
         r_ins  <= InsIn;
         r_rd1  <= w_rd1;
         r_rd2  <= w_rd2;
         r_ed32 <= w_ed32;
         r_npc  <= nextPCIn;
         r_wreg <= w_dest;
      end
   end

   assign Ins    = r_ins;
   assign Rdata1 = r_rd1;
   assign Rdata2 = r_rd2;
   assign Ed32   = r_ed32;
   assign nextPC = r_npc;
   assign Wreg   = r_wreg;
   assign Stall  = w_stall;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the stage.
module tb_decode_stage;
   localparam logic [5:0] T_RF = 6'h00, T_J = 6'h02, T_JAL = 6'h03, T_BEQ = 6'h04,
                          T_ADDI = 6'h08, T_SLTI = 6'h0a, T_LW = 6'h23, T_SW = 6'h2b;

   logic        CLK = 0, RST = 0, Flush = 0, WE = 0;
   logic [31:0] InsIn = 0, nextPCIn = 0, Wdata = 0;
   logic [4:0]  Waddr = 0;
   logic [31:0] Ins, Rdata1, Rdata2, Ed32, nextPC;
   logic [4:0]  Wreg;
   logic        Stall;

   int errors = 0, checks = 0;

   // model state
   logic [31:0] rf [32];
   logic [31:0] m_ins = 0, m_r1 = 0, m_r2 = 0, m_ed = 0, m_npc = 0;
   logic [4:0]  m_wreg = 0;

   decode_stage dut (
      .CLK(CLK), .RST(RST), .InsIn(InsIn), .nextPCIn(nextPCIn), .Flush(Flush),
      .WE(WE), .Waddr(Waddr), .Wdata(Wdata), .Ins(Ins), .Rdata1(Rdata1),
      .Rdata2(Rdata2), .Ed32(Ed32), .nextPC(nextPC), .Wreg(Wreg), .Stall(Stall)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mk_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
      return {T_RF, rs, rt, rd, 5'd0, fn};
   endfunction
   function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [4:0] exp_dest(input logic [31:0] i);
      if (i[31:26] == T_RF) return i[15:11];
      if (i[31:26] == T_LW || i[31:26] == T_ADDI || i[31:26] == T_SLTI) return i[20:16];
      if (i[31:26] == T_JAL) return 5'd31;
      return 5'd0;
   endfunction

   // Value a read of register a returns this cycle, including write-back bypass.
   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 0) return 0;
      if (WE && Waddr == a) return Wdata;
      return rf[a];
   endfunction

   function automatic logic m_stall();
      return (m_ins[31:26] == T_LW) && m_wreg != 0 &&
             (m_wreg == InsIn[25:21] || m_wreg == InsIn[20:16]);
   endfunction

   // Advance one clock: update model from current inputs, then let the DUT edge happen.
   task automatic tick();
      logic st;
      st = m_stall();
      if (RST) begin
         for (int i = 0; i < 32; i++) rf[i] = 0;
         {m_ins, m_r1, m_r2, m_ed, m_npc, m_wreg} = '0;
      end else begin
         if (Flush || st) begin
            {m_ins, m_r1, m_r2, m_ed, m_wreg} = '0;
         end else begin
            m_ins = InsIn; m_r1 = m_read(InsIn[25:21]); m_r2 = m_read(InsIn[20:16]);
            m_ed = {{16{InsIn[15]}}, InsIn[15:0]}; m_wreg = exp_dest(InsIn);
         end
         m_npc = nextPCIn;
         if (WE && Waddr != 0) rf[Waddr] = Wdata;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic fl, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd);
      InsIn = ins; nextPCIn = nextPCIn + 4; Flush = fl; WE = we; Waddr = wa; Wdata = wd;
      #1;
   endtask

   task automatic test_reset();
      RST = 1; drive(32'hFFFF_FFFF, 0, 1, 5'd3, 32'h1111_1111); tick(); RST = 0;
      checks++; if ({Ins, Rdata1, Rdata2, Ed32, nextPC, Wreg} !== '0) begin errors++;
         $display("FAIL reset_outputs: got %h %h %h %h %h %h want all 0", Ins, Rdata1, Rdata2, Ed32, nextPC, Wreg); end
      drive(mk_r(0, 3, 1, 6'h20), 0, 1, 5'd0, 32'hDEAD_BEEF);
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Stall); end
      tick();
      checks++; if (Rdata1 !== 32'h0 || Rdata2 !== 32'h0) begin errors++;
         $display("FAIL r0_bypass_write: got %h/%h want 0/0 (r3 cleared by reset)", Rdata1, Rdata2); end
      drive(mk_r(0, 0, 1, 6'h20), 0, 0, 5'd0, 0); tick();
      checks++; if (Rdata1 !== 32'h0 || Rdata2 !== 32'h0) begin errors++;
         $display("FAIL r0_read: got %h/%h want 0/0", Rdata1, Rdata2); end
   endtask

   task automatic test_bypass();
      drive(mk_r(5, 6, 3, 6'h20), 0, 1, 5'd5, 32'h1234_5678); tick();
      checks++; if (Rdata1 !== 32'h1234_5678) begin errors++;
         $display("FAIL bypass_rdata1: got %h want 12345678", Rdata1); end
      checks++; if (Wreg !== 5'd3 || Ed32 !== 32'h0000_1820) begin errors++;
         $display("FAIL bypass_dest_ed: got wreg=%0d ed=%h want 3 00001820", Wreg, Ed32); end
      drive(mk_r(5, 0, 3, 6'h20), 0, 0, 0, 0); tick();
      checks++; if (Rdata1 !== 32'h1234_5678) begin errors++;
         $display("FAIL array_read_after_write: got %h want 12345678", Rdata1); end
   endtask

   task automatic test_signext();
      drive(mk_i(T_ADDI, 1, 4, 16'hFFFE), 0, 0, 0, 0); tick();
      checks++; if (Ed32 !== 32'hFFFF_FFFE || Wreg !== 5'd4) begin errors++;
         $display("FAIL addi_ed_dest: got ed=%h wreg=%0d want FFFFFFFE 4", Ed32, Wreg); end
      drive(mk_i(T_SW, 1, 4, 16'hFFFE), 0, 0, 0, 0); tick();
      checks++; if (Wreg !== 5'd0 || Ed32 !== 32'hFFFF_FFFE) begin errors++;
         $display("FAIL sw_dest: got wreg=%0d ed=%h want 0 FFFFFFFE", Wreg, Ed32); end
      drive(mk_i(T_JAL, 1, 4, 16'h7FFE), 0, 0, 0, 0); tick();
      checks++; if (Wreg !== 5'd31 || Ed32 !== 32'h0000_7FFE) begin errors++;
         $display("FAIL jal_dest: got wreg=%0d ed=%h want 31 00007FFE", Wreg, Ed32); end
   endtask

   task automatic test_load_use();
      logic [31:0] add_i;
      add_i = mk_r(2, 3, 7, 6'h20);
      drive(mk_i(T_LW, 1, 2, 16'h0), 0, 0, 0, 0); tick();
      drive(add_i, 0, 0, 0, 0);
      checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", Stall); end
      tick();
      checks++; if (Ins !== 32'h0 || Wreg !== 5'd0) begin errors++;
         $display("FAIL lu_bubble: got ins=%h wreg=%0d want 0 0", Ins, Wreg); end
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL lu_stall_clear: got %b want 0", Stall); end
      tick();
      checks++; if (Ins !== add_i || Wreg !== 5'd7) begin errors++;
         $display("FAIL lu_dependent_loaded: got ins=%h wreg=%0d want %h 7", Ins, Wreg, add_i); end
      drive(mk_i(T_LW, 1, 2, 16'h0), 0, 0, 0, 0); tick();
      drive(mk_r(4, 3, 7, 6'h20), 0, 0, 0, 0);
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL lu_independent: got %b want 0", Stall); end
      tick();
   endtask

   task automatic test_flush();
      logic [31:0] npc;
      drive(mk_i(T_LW, 1, 2, 16'h4), 0, 0, 0, 0); tick();
      drive(mk_r(2, 3, 7, 6'h20), 1, 0, 0, 0); npc = nextPCIn;
      checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL flush_stall_comb: got %b want 1", Stall); end
      tick();
      checks++; if (Ins !== 32'h0 || nextPC !== npc) begin errors++;
         $display("FAIL flush_bubble: got ins=%h npc=%h want 0 %h", Ins, nextPC, npc); end
      drive(mk_i(T_ADDI, 1, 4, 16'd5), 1, 0, 0, 0); tick();
      checks++; if (Ins !== 32'h0 || Wreg !== 5'd0) begin errors++;
         $display("FAIL flush_alone: got ins=%h wreg=%0d want 0 0", Ins, Wreg); end
      Flush = 0;
   endtask

   task automatic test_reset_mid();
      drive(mk_r(0, 0, 0, 6'h20), 0, 1, 5'd9, 32'hCAFE_0009); tick();
      drive(mk_i(T_LW, 1, 9, 16'h8), 0, 0, 0, 0); tick();
      RST = 1; drive(mk_r(9, 9, 8, 6'h20), 0, 1, 5'd10, 32'hAAAA_5555); tick(); RST = 0;
      checks++; if ({Ins, Rdata1, Rdata2, Ed32, nextPC, Wreg} !== '0) begin errors++;
         $display("FAIL midreset_outputs: got ins=%h r1=%h wreg=%0d want 0", Ins, Rdata1, Wreg); end
      drive(mk_r(9, 10, 8, 6'h20), 0, 0, 0, 0);
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL midreset_stall: got %b want 0", Stall); end
      tick();
      checks++; if (Rdata1 !== 32'h0 || Rdata2 !== 32'h0) begin errors++;
         $display("FAIL midreset_rf_clear: got %h/%h want 0/0", Rdata1, Rdata2); end
   endtask

   task automatic test_random();
      logic [5:0]  ops [8];
      logic [31:0] ins;
      logic        hold;
      ops = '{T_RF, T_LW, T_LW, T_SW, T_ADDI, T_SLTI, T_BEQ, T_JAL};
      hold = 0; ins = 0;
      for (int c = 0; c < 400; c++) begin
         if (!hold) begin
            ins = $urandom;
            ins[31:26] = ($urandom_range(0, 15) == 0) ? T_J : ops[$urandom_range(0, 7)];
            ins[25:21] = 5'($urandom_range(0, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            if (ins[31:26] == T_RF) ins[15:11] = 5'($urandom_range(0, 7));
         end
         drive(ins, ($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 7)), $urandom);
         RST = ($urandom_range(0, 99) == 0);
         checks++; if (Stall !== m_stall()) begin errors++;
            $display("FAIL rand_stall c=%0d: got %b want %b", c, Stall, m_stall()); end
         hold = m_stall() && !Flush && !RST;
         tick();
         checks++;
         if ({Ins, Rdata1, Rdata2, Ed32, nextPC, Wreg} !== {m_ins, m_r1, m_r2, m_ed, m_npc, m_wreg}) begin
            errors++;
            $display("FAIL rand_idex c=%0d: got %h %h %h %h %h %0d want %h %h %h %h %h %0d", c,
                     Ins, Rdata1, Rdata2, Ed32, nextPC, Wreg, m_ins, m_r1, m_r2, m_ed, m_npc, m_wreg);
         end
      end
      RST = 0; Flush = 0; WE = 0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 0;
      @(posedge CLK); #1;
      test_reset();
      test_bypass();
      test_signext();
      test_load_use();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
